bist_seq_ctrl: RTL and testbench

Parametrised successor to the fixed-pattern BIST controller. It generates a burst pattern on `out`: ON_LEN cycles high, then OFF_LEN cycles low, repeated for SEQ_NUM bursts. ON length, OFF length and burst count are run-time configurable and latched at start. The block adds abort, a burst index, and an abort status flag. It sits between the test-start logic and the circuit under test, and drives the stimulus enable and test-status flags.

---
 rtl/bist_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_bist_seq_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_seq_ctrl.sv
// ============================================================================
// bist_seq_ctrl
// ----------------------------------------------------------------------------
// Burst-pattern BIST sequencer. On a rising edge of `start`, it latches the
// run configuration. It then drives `out` high for ON_LEN cycles and low for
// OFF_LEN cycles, and repeats this for SEQ_NUM bursts before it parks in END.
// A zero configuration field selects a default: ON length -> DEF_ON,
// burst count -> DEF_SEQ. A zero OFF length means bursts run back-to-back
// with no gap.
//
// Optional feature (compile-time macro BIST_SEQ_PAUSE_EN):
//   Adds a `pause` input and a PAUSE state. The block freezes the run while
//   `pause` is high and later resumes exactly where it stopped.
//
// Parameters:
//   PER_W    width of the ON/OFF length counters and config fields
//   SEQ_W    width of the burst counter, burst-count config and seq_idx
//   DEF_ON   ON length used when cfg_on_len == 0
//   DEF_SEQ  burst count used when cfg_seq_num == 0
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high; returns to IDLE
//   start        level; a 0->1 edge requests a run (ignored while running)
//   abort        level; terminates a run in progress (END, aborted=1)
//   pause        (BIST_SEQ_PAUSE_EN only) level; freezes a run in progress
//   cfg_on_len   ON cycles per burst (0 -> DEF_ON)
//   cfg_off_len  OFF cycles between bursts (0 -> no gap)
//   cfg_seq_num  number of bursts (0 -> DEF_SEQ)
//   out          stimulus enable, high in ON
//   running      high in ON/OFF (and PAUSE)
//   bist_end     high in END
//   aborted      high in END when the run was terminated by abort
//   seq_idx      0-based index of the current burst
// ============================================================================
module bist_seq_ctrl #(
    parameter int unsigned PER_W   = 4,
    parameter int unsigned SEQ_W   = 5,
    parameter int unsigned DEF_ON  = 6,
    parameter int unsigned DEF_SEQ = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef BIST_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [PER_W-1:0] cfg_on_len,
    input  logic [PER_W-1:0] cfg_off_len,
    input  logic [SEQ_W-1:0] cfg_seq_num,
    output logic             out,
    output logic             running,
    output logic             bist_end,
    output logic             aborted,
    output logic [SEQ_W-1:0] seq_idx
);

    localparam logic [PER_W-1:0] DEF_ON_V  = PER_W'(DEF_ON);
    localparam logic [SEQ_W-1:0] DEF_SEQ_V = SEQ_W'(DEF_SEQ);
    localparam logic [PER_W-1:0] PER_ONE   = PER_W'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);

`ifdef BIST_SEQ_PAUSE_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ON    = 3'd1,
        ST_OFF   = 3'd2,
        ST_END   = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_END  = 2'd3
    } state_t;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [PER_W-1:0] per_cnt_q,    per_cnt_d;
    logic [SEQ_W-1:0] seq_idx_q,    seq_idx_d;
    logic [PER_W-1:0] on_len_q,     on_len_d;
    logic [PER_W-1:0] off_len_q,    off_len_d;
    logic [SEQ_W-1:0] seq_num_q,    seq_num_d;
    logic             prev_start_q, prev_start_d;
    logic             aborted_q,    aborted_d;
`ifdef BIST_SEQ_PAUSE_EN
    state_t           ret_state_q,  ret_state_d;
`endif

    // Registered Moore outputs, decoded from the next state.
    logic             out_q,        out_d;
    logic             running_q,    running_d;
    logic             bist_end_q,   bist_end_d;

    logic             new_seq;
    logic             on_term;
    logic             off_term;
    logic             last_burst;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        seq_idx_d    = seq_idx_q;
        on_len_d     = on_len_q;
        off_len_d    = off_len_q;
        seq_num_d    = seq_num_q;
        aborted_d    = aborted_q;
        prev_start_d = start;
`ifdef BIST_SEQ_PAUSE_EN
        ret_state_d  = ret_state_q;
`endif

        // running_q mirrors the current state, so it can be used directly
        // for edge qualification.
        new_seq    = start & ~prev_start_q & ~running_q & ~reset;

        // Latched lengths are always >= 1 (on/seq) or only used when >= 1
        // (off), so the "-1" terminal values never underflow.
        on_term    = (per_cnt_q == (on_len_q  - PER_ONE));
        off_term   = (per_cnt_q == (off_len_q - PER_ONE));
        last_burst = (seq_idx_q == (seq_num_q - SEQ_ONE));

        case (state_q)
            ST_IDLE, ST_END: begin
                if (new_seq) begin
                    state_d   = ST_ON;
                    per_cnt_d = '0;
                    seq_idx_d = '0;
                    aborted_d = 1'b0;
                    on_len_d  = (cfg_on_len  == '0) ? DEF_ON_V  : cfg_on_len;
                    off_len_d = cfg_off_len;
                    seq_num_d = (cfg_seq_num == '0) ? DEF_SEQ_V : cfg_seq_num;
                end
            end

            ST_ON: begin
                if (abort) begin
                    state_d   = ST_END;
                    aborted_d = 1'b1;
                end else if (on_term) begin
                    if (last_burst) begin
                        state_d = ST_END;
                    end else if (off_len_q == '0) begin
                        // No gap: roll straight into the next burst.
                        state_d   = ST_ON;
                        per_cnt_d = '0;
                        seq_idx_d = seq_idx_q + SEQ_ONE;
                    end else begin
                        state_d   = ST_OFF;
                        per_cnt_d = '0;
                    end
                end else begin
                    per_cnt_d = per_cnt_q + PER_ONE;
                end
            end

            ST_OFF: begin
                if (abort) begin
                    state_d   = ST_END;
                    aborted_d = 1'b1;
                end else if (off_term) begin
                    state_d   = ST_ON;
                    per_cnt_d = '0;
                    seq_idx_d = seq_idx_q + SEQ_ONE;
                end else begin
                    per_cnt_d = per_cnt_q + PER_ONE;
                end
            end

`ifdef BIST_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (abort) begin
                    state_d   = ST_END;
                    aborted_d = 1'b1;
                end else if (!pause) begin
                    state_d = ret_state_q;
                end
            end
`endif

            default: begin
                state_d   = ST_IDLE;
                per_cnt_d = '0;
                seq_idx_d = '0;
                aborted_d = 1'b0;
            end
        endcase

`ifdef BIST_SEQ_PAUSE_EN
        // The cycle that samples pause still advances normally. The advanced
        // state and counters are parked, so that resuming continues from the
        // next unexecuted cycle. A run that is finishing goes to END instead
        // of pausing. Abort has already redirected state_d to END here.
        if (pause && !abort &&
            (state_q == ST_ON || state_q == ST_OFF) &&
            (state_d == ST_ON || state_d == ST_OFF)) begin
            ret_state_d = state_d;
            state_d     = ST_PAUSE;
        end
`endif

        out_d      = (state_d == ST_ON);
        bist_end_d = (state_d == ST_END);
`ifdef BIST_SEQ_PAUSE_EN
        running_d  = (state_d == ST_ON) || (state_d == ST_OFF) ||
                     (state_d == ST_PAUSE);
`else
        running_d  = (state_d == ST_ON) || (state_d == ST_OFF);
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            per_cnt_q    <= '0;
            seq_idx_q    <= '0;
            on_len_q     <= '0;
            off_len_q    <= '0;
            seq_num_q    <= '0;
            prev_start_q <= 1'b0;
            aborted_q    <= 1'b0;
`ifdef BIST_SEQ_PAUSE_EN
            ret_state_q  <= ST_IDLE;
`endif
            out_q        <= 1'b0;
            running_q    <= 1'b0;
            bist_end_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            seq_idx_q    <= seq_idx_d;
            on_len_q     <= on_len_d;
            off_len_q    <= off_len_d;
            seq_num_q    <= seq_num_d;
            prev_start_q <= prev_start_d;
            aborted_q    <= aborted_d;
`ifdef BIST_SEQ_PAUSE_EN
            ret_state_q  <= ret_state_d;
`endif
            out_q        <= out_d;
            running_q    <= running_d;
            bist_end_q   <= bist_end_d;
        end
    end

    assign out      = out_q;
    assign running  = running_q;
    assign bist_end = bist_end_q;
    assign aborted  = aborted_q;
    assign seq_idx  = seq_idx_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// ============================================================================
// tb_bist_seq_ctrl
// ----------------------------------------------------------------------------
// Bench for bist_seq_ctrl. When a scenario drives a run, it pushes the
// expected per-cycle outputs into a queue. Each following cycle pops one
// entry from the queue and compares it with the DUT outputs.
// ============================================================================
module tb_bist_seq_ctrl;

    localparam int PER_W = 4;
    localparam int SEQ_W = 5;

    typedef struct packed {
        logic             out;
        logic             running;
        logic             bist_end;
        logic             aborted;
        logic [SEQ_W-1:0] seq_idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
`ifdef BIST_SEQ_PAUSE_EN
    logic             pause;
`endif
    logic [PER_W-1:0] cfg_on_len;
    logic [PER_W-1:0] cfg_off_len;
    logic [SEQ_W-1:0] cfg_seq_num;
    logic             out;
    logic             running;
    logic             bist_end;
    logic             aborted;
    logic [SEQ_W-1:0] seq_idx;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bist_seq_ctrl #(
        .PER_W  (PER_W),
        .SEQ_W  (SEQ_W),
        .DEF_ON (6),
        .DEF_SEQ(12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
`ifdef BIST_SEQ_PAUSE_EN
        .pause      (pause),
`endif
        .cfg_on_len (cfg_on_len),
        .cfg_off_len(cfg_off_len),
        .cfg_seq_num(cfg_seq_num),
        .out        (out),
        .running    (running),
        .bist_end   (bist_end),
        .aborted    (aborted),
        .seq_idx    (seq_idx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t observe();
        return {out, running, bist_end, aborted, seq_idx};
    endfunction

    function automatic exp_t mk(input logic o, input logic r, input logic e,
                                input logic a, input int unsigned idx);
        exp_t v;
        v.out      = o;
        v.running  = r;
        v.bist_end = e;
        v.aborted  = a;
        v.seq_idx  = SEQ_W'(idx);
        return v;
    endfunction

    // Reference model: expected outputs for every running cycle of a run.
    task automatic push_run(input int unsigned on_len, input int unsigned off_len,
                            input int unsigned seq_num);
        for (int unsigned b = 0; b < seq_num; b++) begin
            for (int unsigned i = 0; i < on_len; i++)
                exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, b));
            if (b != seq_num - 1)
                for (int unsigned i = 0; i < off_len; i++)
                    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, b));
        end
    endtask

    task automatic set_cfg(input int unsigned on_len, input int unsigned off_len,
                           input int unsigned seq_num);
        cfg_on_len  = PER_W'(on_len);
        cfg_off_len = PER_W'(off_len);
        cfg_seq_num = SEQ_W'(seq_num);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        exp_t o;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef BIST_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        set_cfg(0, 0, 0);
        tick; tick;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL reset_state: got %b want %b", o, mk(0, 0, 0, 0, 0));
        end
        reset = 1'b0;
        tick;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b want %b", o, mk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_default_run;
        exp_t o, e;
        int   n = 0;
        set_cfg(0, 0, 0);
        start = 1'b1;
        push_run(6, 0, 12);
        while (exp_q.size() != 0) begin
            tick;
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL default_run cyc %0d: got %b want %b", n, o, e);
            end
            n++;
        end
        tick;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 1, 0, 11)) begin
            tests_failed++;
            $display("FAIL default_end: got %b want %b", o, mk(0, 0, 1, 0, 11));
        end
        start = 1'b0;
        tick;
    endtask

    task automatic test_pattern;
        exp_t o, e;
        int   k = 0;
        int   run_cnt = 0;
        set_cfg(3, 2, 4);
        start = 1'b1;
        push_run(3, 2, 4);
        while (exp_q.size() != 0) begin
            tick;
            k++;
            e = exp_q.pop_front();
            o = observe();
            if (running) run_cnt++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL pattern cyc %0d: got %b want %b", k, o, e);
            end
            // Config changes mid-run must not affect the latched values.
            if (k == 5) set_cfg(1, 1, 1);
        end
        tick;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 1, 0, 3)) begin
            tests_failed++;
            $display("FAIL pattern_end: got %b want %b", o, mk(0, 0, 1, 0, 3));
        end
        tests_run++;
        if (run_cnt != 18) begin
            tests_failed++;
            $display("FAIL pattern_running_len: got %0d want 18", run_cnt);
        end
        start = 1'b0;
        tick;
    endtask

    task automatic test_abort;
        exp_t o, e;
        int   k = 0;
        set_cfg(3, 2, 4);
        start = 1'b1;
        push_run(3, 2, 4);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        while (exp_q.size() != 0) begin
            tick;
            k++;
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL abort_run cyc %0d: got %b want %b", k, o, e);
            end
            if (k == 1) start = 1'b0;
            // Second OFF cycle of burst 1.
            if (k == 10) abort = 1'b1;
        end
        tick;
        abort = 1'b0;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 1, 1, 1)) begin
            tests_failed++;
            $display("FAIL abort_end: got %b want %b", o, mk(0, 0, 1, 1, 1));
        end
        // Abort in END is ignored and aborted holds.
        abort = 1'b1;
        tick;
        abort = 1'b0;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 1, 1, 1)) begin
            tests_failed++;
            $display("FAIL abort_in_end: got %b want %b", o, mk(0, 0, 1, 1, 1));
        end
    endtask

    task automatic test_start_held;
        exp_t o, e;
        int   k = 0;
        set_cfg(2, 1, 3);
        start = 1'b1;
        push_run(2, 1, 3);
        while (exp_q.size() != 0) begin
            tick;
            k++;
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL held_run cyc %0d: got %b want %b", k, o, e);
            end
            // Extra edge while running must be ignored.
            if (k == 3) start = 1'b0;
            if (k == 5) start = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            o = observe();
            tests_run++;
            if (o !== mk(0, 0, 1, 0, 2)) begin
                tests_failed++;
                $display("FAIL held_end %0d: got %b want %b", i, o, mk(0, 0, 1, 0, 2));
            end
        end
        start = 1'b0;
        tick;
        start = 1'b1;
        push_run(2, 1, 3);
        k = 0;
        while (exp_q.size() != 0) begin
            tick;
            k++;
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL restart_run cyc %0d: got %b want %b", k, o, e);
            end
        end
        tick;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 1, 0, 2)) begin
            tests_failed++;
            $display("FAIL restart_end: got %b want %b", o, mk(0, 0, 1, 0, 2));
        end
        start = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_run;
        exp_t o, e;
        int   k = 0;
        set_cfg(3, 2, 4);
        start = 1'b1;
        push_run(3, 2, 4);
        while (exp_q.size() > 12) void'(exp_q.pop_back());
        while (exp_q.size() != 0) begin
            tick;
            k++;
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rst_run cyc %0d: got %b want %b", k, o, e);
            end
            if (k == 1) start = 1'b0;
            // Middle ON cycle of burst 2.
            if (k == 12) reset = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            if (i == 1) reset = 1'b0;
            o = observe();
            tests_run++;
            if (o !== mk(0, 0, 0, 0, 0)) begin
                tests_failed++;
                $display("FAIL rst_zero %0d: got %b want %b", i, o, mk(0, 0, 0, 0, 0));
            end
        end
        set_cfg(4, 1, 2);
        start = 1'b1;
        push_run(4, 1, 2);
        k = 0;
        while (exp_q.size() != 0) begin
            tick;
            k++;
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rst_rerun cyc %0d: got %b want %b", k, o, e);
            end
        end
        tick;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 1, 0, 1)) begin
            tests_failed++;
            $display("FAIL rst_rerun_end: got %b want %b", o, mk(0, 0, 1, 0, 1));
        end
        start = 1'b0;
        tick;
    endtask

`ifdef BIST_SEQ_PAUSE_EN
    task automatic test_pause;
        exp_t o, e;
        int   k = 0;
        int   run_cnt = 0;
        set_cfg(3, 2, 4);
        start = 1'b1;
        push_run(3, 2, 4);
        for (int i = 0; i < 5; i++) exp_q.insert(1, mk(0, 1, 0, 0, 0));
        while (exp_q.size() != 0) begin
            tick;
            k++;
            e = exp_q.pop_front();
            o = observe();
            if (running) run_cnt++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL pause_run cyc %0d: got %b want %b", k, o, e);
            end
            if (k == 1) start = 1'b0;
            pause = (k <= 5);
        end
        tick;
        o = observe();
        tests_run++;
        if (o !== mk(0, 0, 1, 0, 3)) begin
            tests_failed++;
            $display("FAIL pause_end: got %b want %b", o, mk(0, 0, 1, 0, 3));
        end
        tests_run++;
        if (run_cnt != 23) begin
            tests_failed++;
            $display("FAIL pause_running_len: got %0d want 23", run_cnt);
        end
        tick;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_run();
        test_pattern();
        test_abort();
        test_start_held();
        test_reset_mid_run();
`ifdef BIST_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
